sme_driver: RTL

SME_DRIVER -- requirements
Module: sme_driver

---
 rtl/sme_driver.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sme_driver.sv
// sme_driver: buffers one string and four patterns, streams them into a matcher
// engine and returns one result per non-empty pattern slot.
module sme_driver (
    input  logic       clk,
    input  logic       reset,
    input  logic       str_we,
    input  logic [7:0] str_wdata,
    input  logic       pat_we,
    input  logic [1:0] pat_id,
    input  logic [7:0] pat_wdata,
    input  logic       clr,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       res_valid,
    output logic [1:0] res_id,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       sme_rst,
    output logic [7:0] sme_chardata,
    output logic       sme_isstring,
    output logic       sme_ispattern,
    input  logic       sme_valid,
    input  logic       sme_match,
    input  logic [4:0] sme_match_index
);
    localparam int unsigned STR_DEPTH = 32;
    localparam int unsigned PAT_DEPTH = 8;
    localparam int unsigned NUM_PAT   = 4;
    localparam int unsigned STR_LEN_W = 6;
    localparam int unsigned PAT_LEN_W = 4;
    localparam int unsigned PAT_IDX_W = 3;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned SLOT_W    = 2;
    localparam int unsigned WCNT_W    = 10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RST      = 3'd1,
        SEND_STR = 3'd2,
        SEND_PAT = 3'd3,
        WAIT_RES = 3'd4,
        DONE     = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [WCNT_W-1:0]      wcnt_q, wcnt_d;
    logic [STR_LEN_W-1:0]   str_len_q, str_len_d;
    logic [PAT_LEN_W-1:0]   pat_len_q [NUM_PAT];
    logic [PAT_LEN_W-1:0]   pat_len_d [NUM_PAT];
    logic [7:0]             str_mem_q [STR_DEPTH];
    logic [7:0]             str_mem_d [STR_DEPTH];
    logic [7:0]             pat_mem_q [NUM_PAT][PAT_DEPTH];
    logic [7:0]             pat_mem_d [NUM_PAT][PAT_DEPTH];
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   res_valid_q, res_valid_d;
    logic [SLOT_W-1:0]      res_id_q, res_id_d;
    logic                   res_match_q, res_match_d;
    logic [IDX_W-1:0]       res_index_q, res_index_d;

    logic                   host_ok;
    logic                   first_found, next_found;
    logic [SLOT_W-1:0]      first_slot, next_slot;

    assign host_ok = (state_q == IDLE) || (state_q == DONE);

    // Host-side buffer writes and length bookkeeping; clr wins over writes.
    always_comb begin
        str_mem_d = str_mem_q;
        pat_mem_d = pat_mem_q;
        str_len_d = str_len_q;
        pat_len_d = pat_len_q;
        if (host_ok) begin
            if (clr) begin
                str_len_d = '0;
                pat_len_d = '{default: '0};
            end else begin
                if (str_we && (str_len_q != STR_LEN_W'(STR_DEPTH))) begin
                    str_mem_d[str_len_q[IDX_W-1:0]] = str_wdata;
                    str_len_d = str_len_q + STR_LEN_W'(1);
                end
                if (pat_we && (pat_len_q[pat_id] != PAT_LEN_W'(PAT_DEPTH))) begin
                    pat_mem_d[pat_id][pat_len_q[pat_id][PAT_IDX_W-1:0]] = pat_wdata;
                    pat_len_d[pat_id] = pat_len_q[pat_id] + PAT_LEN_W'(1);
                end
            end
        end
    end

    // Lowest non-empty slot overall, and lowest non-empty slot above the current one.
    always_comb begin
        first_found = 1'b0;
        first_slot  = '0;
        next_found  = 1'b0;
        next_slot   = '0;
        for (int j = int'(NUM_PAT) - 1; j >= 0; j--) begin
            if (pat_len_q[j] != '0) begin
                first_found = 1'b1;
                first_slot  = SLOT_W'(j);
                if (j > int'(slot_q)) begin
                    next_found = 1'b1;
                    next_slot  = SLOT_W'(j);
                end
            end
        end
    end

    // Run sequencer: next state, matcher stream and result/status updates.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        slot_d        = slot_q;
        wcnt_d        = wcnt_q;
        busy_d        = busy_q;
        done_d        = done_q;
        err_d         = err_q;
        res_valid_d   = 1'b0;
        res_id_d      = res_id_q;
        res_match_d   = res_match_q;
        res_index_d   = res_index_q;
        sme_rst       = 1'b0;
        sme_isstring  = 1'b0;
        sme_ispattern = 1'b0;
        sme_chardata  = '0;
        case (state_q)
            IDLE, DONE: begin
                if (start && !clr && (str_len_q != '0) && first_found) begin
                    state_d = RST;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            RST: begin
                sme_rst = 1'b1;
                state_d = SEND_STR;
                idx_d   = '0;
            end
            SEND_STR: begin
                sme_isstring = 1'b1;
                sme_chardata = str_mem_q[idx_q];
                if ({1'b0, idx_q} == (str_len_q - STR_LEN_W'(1))) begin
                    state_d = SEND_PAT;
                    slot_d  = first_slot;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            SEND_PAT: begin
                sme_ispattern = 1'b1;
                sme_chardata  = pat_mem_q[slot_q][idx_q[PAT_IDX_W-1:0]];
                if (idx_q == {1'b0, pat_len_q[slot_q] - PAT_LEN_W'(1)}) begin
                    state_d = WAIT_RES;
                    wcnt_d  = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            WAIT_RES: begin
                if (sme_valid) begin
                    res_valid_d = 1'b1;
                    res_id_d    = slot_q;
                    res_match_d = sme_match;
                    res_index_d = sme_match_index;
                    if (next_found) begin
                        // Next pattern's first byte rides in the result cycle.
                        sme_ispattern = 1'b1;
                        sme_chardata  = pat_mem_q[next_slot][0];
                        slot_d        = next_slot;
                        wcnt_d        = '0;
                        if (pat_len_q[next_slot] == PAT_LEN_W'(1)) begin
                            state_d = WAIT_RES;
                        end else begin
                            state_d = SEND_PAT;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else if (wcnt_q == '1) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Buffer storage; contents survive runs and reset, lengths decide validity.
    always_ff @(posedge clk) begin
        str_mem_q <= str_mem_d;
        pat_mem_q <= pat_mem_d;
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            slot_q      <= '0;
            wcnt_q      <= '0;
            str_len_q   <= '0;
            pat_len_q   <= '{default: '0};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_match_q <= 1'b0;
            res_index_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            slot_q      <= slot_d;
            wcnt_q      <= wcnt_d;
            str_len_q   <= str_len_d;
            pat_len_q   <= pat_len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_id_q    <= res_id_d;
            res_match_q <= res_match_d;
            res_index_q <= res_index_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_match = res_match_q;
    assign res_index = res_index_q;

endmodule
